// File: rtl/bridge_arb_pkg.sv
// -----------------------------------------------------------------------------
// bridge_arb_pkg
// Shared types and helpers for the bridge client arbiter.
//   ARB_STATE    : arbiter FSM state encoding (idle / issue / wait)
//   clog2_min1() : client index width, never narrower than one bit
//   RESP_OKAY    : AXI4-Lite OKAY write response code
// -----------------------------------------------------------------------------
package bridge_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'b00,
      ARB_ISSUE = 2'b01,
      ARB_WAIT  = 2'b10
   } ARB_STATE;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Index width for n clients; a single-bit index is kept even for n <= 2.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: grants the lowest requesting index at
// or above ptr, wrapping around to index 0.
//   req       in  N   request vector
//   ptr       in  IW  index with highest priority this cycle
//   grant     out N   one-hot grant (all zero when nothing requests)
//   grant_idx out IW  binary index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic          found_s;
   logic [IW:0]   sum_s;
   logic [IW-1:0] idx_s;

   // Scan N slots starting at ptr and take the first active request.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found_s   = 1'b0;
      sum_s     = '0;
      idx_s     = '0;
      for (int k = 0; k < N; k++) begin
         sum_s = {1'b0, ptr} + (IW+1)'(k);
         // ptr < N and k < N, so one subtraction is enough to wrap.
         if (sum_s >= (IW+1)'(N)) begin
            sum_s = sum_s - (IW+1)'(N);
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[IW-1:0];
         if (!found_s && req[idx_s]) begin
            grant[idx_s] = 1'b1;
            grant_idx    = idx_s;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/bridge_client_arb.sv
// -----------------------------------------------------------------------------
// bridge_client_arb
// Round-robin arbiter in front of the command port of the valid-handshake to
// AXI4-Lite bridge. One transaction is outstanding at a time; the bridge result
// is returned to the owning client as a one-cycle response pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-client request handshake (ready is one-hot)
//   req_r_wb/addr/data_w     packed per-client request payload
//   resp_valid/resp_data     one-hot response pulse and its data
//   C_in_valid/C_r_wb/C_addr/C_data_w   command to the bridge
//   C_out_valid/C_data_r     completion from the bridge
//   perf_cnt                 per-client completed-transaction counters, only
//                            present when BRIDGE_ARB_PERF_EN is defined
// -----------------------------------------------------------------------------
module bridge_client_arb
   import bridge_arb_pkg::*;
#(
   parameter int N_CLIENT = 2,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_CLIENT-1:0]        req_valid,
   output logic [N_CLIENT-1:0]        req_ready,
   input  logic [N_CLIENT-1:0]        req_r_wb,
   input  logic [N_CLIENT*ADDR_W-1:0] req_addr,
   input  logic [N_CLIENT*DATA_W-1:0] req_data_w,
   output logic [N_CLIENT-1:0]        resp_valid,
   output logic [DATA_W-1:0]          resp_data,
   output logic                       C_in_valid,
   output logic                       C_r_wb,
   output logic [ADDR_W-1:0]          C_addr,
   output logic [DATA_W-1:0]          C_data_w,
   input  logic                       C_out_valid,
   input  logic [DATA_W-1:0]          C_data_r
`ifdef BRIDGE_ARB_PERF_EN
   ,
   output logic [N_CLIENT*16-1:0]     perf_cnt
`endif
);

   localparam int CLIENT_IDX_W = clog2_min1(N_CLIENT);

   ARB_STATE                state_q, state_d;
   logic [CLIENT_IDX_W-1:0] owner_q, owner_d;
   logic [CLIENT_IDX_W-1:0] ptr_q, ptr_d;
   logic                    c_in_valid_q, c_in_valid_d;
   logic                    c_r_wb_q, c_r_wb_d;
   logic [ADDR_W-1:0]       c_addr_q, c_addr_d;
   logic [DATA_W-1:0]       c_data_w_q, c_data_w_d;
   logic [N_CLIENT-1:0]     resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]       resp_data_q, resp_data_d;

   logic [N_CLIENT-1:0]     grant_s;
   logic [CLIENT_IDX_W-1:0] grant_idx_s;
   logic                    accept_s;
   logic                    sel_r_wb_s;
   logic [ADDR_W-1:0]       sel_addr_s;
   logic [DATA_W-1:0]       sel_data_s;

   rr_arbiter #(
      .N  (N_CLIENT),
      .IW (CLIENT_IDX_W)
   ) u_rr (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
   );

   // Grants are only offered while idle; any grant is then an accept.
   assign req_ready = (state_q == ARB_IDLE) ? grant_s : '0;
   assign accept_s  = |req_ready;

   // Payload mux driven by the one-hot grant.
   always_comb begin
      sel_r_wb_s = 1'b0;
      sel_addr_s = '0;
      sel_data_s = '0;
      for (int i = 0; i < N_CLIENT; i++) begin
         if (grant_s[i]) begin
            sel_r_wb_s = req_r_wb[i];
            sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
            sel_data_s = req_data_w[i*DATA_W +: DATA_W];
         end else begin
            sel_r_wb_s = sel_r_wb_s;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; completions outside ARB_WAIT are ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (accept_s) begin
               state_d = ARB_ISSUE;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_ISSUE: state_d = ARB_WAIT;
         ARB_WAIT: begin
            if (C_out_valid) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = ARB_WAIT;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // FSM outputs: next values of the command, owner, pointer and response flops.
   always_comb begin
      owner_d      = owner_q;
      ptr_d        = ptr_q;
      c_in_valid_d = 1'b0;
      c_r_wb_d     = c_r_wb_q;
      c_addr_d     = c_addr_q;
      c_data_w_d   = c_data_w_q;
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      if (accept_s) begin
         owner_d      = grant_idx_s;
         ptr_d        = (grant_idx_s == CLIENT_IDX_W'(N_CLIENT - 1)) ? '0
                                                                     : grant_idx_s + CLIENT_IDX_W'(1);
         c_in_valid_d = 1'b1;
         c_r_wb_d     = sel_r_wb_s;
         c_addr_d     = sel_addr_s;
         c_data_w_d   = sel_data_s;
      end else begin
         c_in_valid_d = 1'b0;
      end
      if ((state_q == ARB_WAIT) && C_out_valid) begin
         resp_valid_d[owner_q] = 1'b1;
         resp_data_d           = C_data_r;
      end else begin
         resp_valid_d = '0;
      end
   end

   // Command, owner, pointer and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q      <= '0;
         ptr_q        <= '0;
         c_in_valid_q <= 1'b0;
         c_r_wb_q     <= 1'b0;
         c_addr_q     <= '0;
         c_data_w_q   <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
      end else begin
         owner_q      <= owner_d;
         ptr_q        <= ptr_d;
         c_in_valid_q <= c_in_valid_d;
         c_r_wb_q     <= c_r_wb_d;
         c_addr_q     <= c_addr_d;
         c_data_w_q   <= c_data_w_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign C_in_valid = c_in_valid_q;
   assign C_r_wb     = c_r_wb_q;
   assign C_addr     = c_addr_q;
   assign C_data_w   = c_data_w_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;

`ifdef BRIDGE_ARB_PERF_EN
   logic [N_CLIENT*16-1:0] perf_q, perf_d;

   // Saturating per-client count of issued response pulses.
   always_comb begin
      perf_d = perf_q;
      for (int i = 0; i < N_CLIENT; i++) begin
         if (resp_valid_q[i] && (perf_q[i*16 +: 16] != 16'hFFFF)) begin
            perf_d[i*16 +: 16] = perf_q[i*16 +: 16] + 16'd1;
         end else begin
            perf_d[i*16 +: 16] = perf_q[i*16 +: 16];
         end
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cnt = perf_q;
`endif

endmodule
